// File: rtl/keypad_matrix_scanner.sv
// Row-scanning matrix keypad front end with per-key debounce and a key event FIFO.
// Optional macro KEYPAD_RELEASE_EVT_EN: also queue release events (otherwise presses only).
module keypad_matrix_scanner #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 25000,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4,
   localparam int KEYS          = ROWS * COLS,
   localparam int KW            = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [COLS-1:0]   col_in,
   output logic [ROWS-1:0]   row_out,
   output logic [KEYS-1:0]   key_state,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [KW-1:0]     evt_code,
   output logic              evt_press,
   output logic              overflow
);

   localparam int RW   = $clog2(ROWS);
   localparam int CW   = $clog2(COLS);
   localparam int DW   = $clog2(SCAN_DIV);
   localparam int CNTW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam int EW   = KW + 1;
`else
   localparam int EW   = KW;
`endif

   localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0]   EVAL_END   = DW'(COLS);
   localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
   localparam logic [CNTW-1:0] DEB_LAST   = CNTW'(DEBOUNCE_SCANS);
   localparam logic [AW:0]     FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

   logic [COLS-1:0] col_meta;
   logic [COLS-1:0] col_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta <= '1;
         col_sync <= '1;
      end else begin
         col_meta <= col_in;
         col_sync <= col_meta;
      end
   end

   logic [DW-1:0] dwell_cnt;
   logic [RW-1:0] row_idx;
   logic          dwell_wrap;

   assign dwell_wrap = (dwell_cnt == DWELL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_cnt <= '0;
         row_idx   <= '0;
      end else if (dwell_wrap) begin
         dwell_cnt <= '0;
         row_idx   <= (row_idx == ROW_LAST) ? '0 : row_idx + RW'(1);
      end else begin
         dwell_cnt <= dwell_cnt + DW'(1);
      end
   end

   // Registered drive lags row_idx by one cycle, so the first cycle out of reset drives no row.
   always_ff @(posedge clk) begin
      if (rst) row_out <= '1;
      else     row_out <= ~(ROWS'(1) << row_idx);
   end

   logic [COLS-1:0] sample_cols;
   logic [RW-1:0]   sample_row;

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cols <= '1;
         sample_row  <= '0;
      end else if (dwell_wrap) begin
         sample_cols <= col_sync;
         sample_row  <= row_idx;
      end
   end

   logic            eval_active;
   logic [CW-1:0]   eval_col;
   logic [KW-1:0]   eval_key;
   logic [CNTW-1:0] deb_cnt [KEYS];
   logic [CNTW-1:0] cur_cnt;
   logic [CNTW-1:0] cnt_inc;
   logic            cur_state;
   logic            sample_closed;
   logic            disagree;
   logic            flip;

   assign eval_active = (dwell_cnt < EVAL_END);
   assign eval_col    = CW'(dwell_cnt);
   assign eval_key    = KW'(KW'(sample_row) * KW'(COLS) + KW'(eval_col));

   always_comb begin
      cur_state     = key_state[eval_key];
      cur_cnt       = deb_cnt[eval_key];
      sample_closed = ~sample_cols[eval_col];
      disagree      = eval_active && (sample_closed != cur_state);
      cnt_inc       = cur_cnt + CNTW'(1);
      flip          = disagree && (cnt_inc == DEB_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_state <= '0;
         for (int k = 0; k < KEYS; k++) deb_cnt[k] <= '0;
      end else if (eval_active) begin
         if (!disagree) begin
            deb_cnt[eval_key] <= '0;
         end else if (flip) begin
            deb_cnt[eval_key]   <= '0;
            key_state[eval_key] <= ~cur_state;
         end else begin
            deb_cnt[eval_key] <= cnt_inc;
         end
      end
   end

   logic          push_req;
   logic [EW-1:0] push_data;
   logic [EW-1:0] fifo_head;

`ifdef KEYPAD_RELEASE_EVT_EN
   assign push_req  = flip;
   assign push_data = {eval_key, ~cur_state};
   assign evt_press = fifo_head[0];
`else
   // Releases still update key_state but never enter the queue.
   assign push_req  = flip && !cur_state;
   assign push_data = eval_key;
   assign evt_press = 1'b1;
`endif

   // Event handshake: the head is offered while evt_valid is high and is consumed on a
   // cycle where evt_valid && evt_ready; until then evt_code/evt_press hold their values.
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   fifo_count;
   logic          fifo_full;
   logic          pop;
   logic          push_ok;

   assign fifo_full = (fifo_count == FIFO_FULL);
   assign evt_valid = (fifo_count != '0);
   assign pop       = evt_valid && evt_ready;
   assign push_ok   = push_req && (!fifo_full || pop);
   assign fifo_head = fifo_mem[rd_ptr];
   assign evt_code  = fifo_head[EW-1 -: KW];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push_req && !push_ok) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: keypad model drives col_in, a cycle model of the
// scan/debounce/queue rules is compared every cycle, plus directed literal checks.
module tb_keypad_matrix_scanner;

   localparam int ROWS     = 4;
   localparam int COLS     = 4;
   localparam int SCAN_DIV = 8;
   localparam int DEB      = 3;
   localparam int DEPTH    = 4;
   localparam int KW       = 4;
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam bit RELEASE_EN = 1'b1;
`else
   localparam bit RELEASE_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [COLS-1:0]      col_in;
   logic [ROWS-1:0]      row_out;
   logic [ROWS*COLS-1:0] key_state;
   logic                 evt_valid;
   logic                 evt_ready = 1'b0;
   logic [KW-1:0]        evt_code;
   logic                 evt_press;
   logic                 overflow;

   keypad_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
      .key_state(key_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_code(evt_code), .evt_press(evt_press), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Physical keypad: a held key pulls its column low while its row is driven.
   logic [ROWS*COLS-1:0] pressed = '0;
   always_comb begin
      col_in = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!row_out[r] && pressed[r*COLS+c]) col_in[c] = 1'b0;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state; cyc counts cycles since reset release.
   bit                   model_on = 1'b0;
   int                   cyc;
   logic [ROWS*COLS-1:0] m_state;
   int                   m_run [ROWS*COLS];
   logic [COLS-1:0]      pend;
   logic [COLS-1:0]      samp;
   int                   samp_row;
   bit                   samp_ok;
   bit                   m_ovf;
   logic [KW:0]          exp_q[$];
   logic [KW:0]          pop_log[$];
   int                   valid_cycles;

   task automatic model_reset();
      cyc      = 0;
      m_state  = '0;
      for (int k = 0; k < ROWS*COLS; k++) m_run[k] = 0;
      pend     = '0;
      samp     = '0;
      samp_row = 0;
      samp_ok  = 1'b0;
      m_ovf    = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic [ROWS-1:0] exp_row(input int n);
      logic [ROWS-1:0] one_hot;
      if (n == 0) return '1;
      one_hot = ROWS'(1) << (((n - 1) / SCAN_DIV) % ROWS);
      return ~one_hot;
   endfunction

   // Advance the model across the coming clock edge.
   task automatic model_step();
      int          cnt;
      int          row;
      int          k;
      bit          do_push;
      bit          do_pop;
      logic [KW:0] ev;
      cnt     = cyc % SCAN_DIV;
      row     = (cyc / SCAN_DIV) % ROWS;
      do_pop  = (exp_q.size() != 0) && evt_ready;
      do_push = 1'b0;
      ev      = '0;
      if (cnt < COLS && samp_ok) begin
         k = samp_row * COLS + cnt;
         if (samp[cnt] == m_state[k]) begin
            m_run[k] = 0;
         end else begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
               m_state[k] = ~m_state[k];
               m_run[k]   = 0;
               ev         = {KW'(k), m_state[k]};
               do_push    = RELEASE_EN || m_state[k];
            end
         end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(ev);
         else m_ovf = 1'b1;
      end
      if (cnt == SCAN_DIV - 3)
         for (int c = 0; c < COLS; c++) pend[c] = pressed[row*COLS+c];
      if (cnt == SCAN_DIV - 1) begin
         samp     = pend;
         samp_row = row;
         samp_ok  = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         check("row_out", row_out, exp_row(cyc));
         check("key_state", key_state, m_state);
         check("evt_valid", evt_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            check("evt_code", evt_code, exp_q[0][KW:1]);
            check("evt_press", evt_press, exp_q[0][0]);
         end
         check("overflow", overflow, m_ovf);
         if (evt_valid && evt_ready) pop_log.push_back({evt_code, evt_press});
         if (evt_valid) valid_cycles++;
         model_step();
         cyc++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      model_on = 1'b0;
      pressed  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_row_out", row_out, 4'hF);
      check("rst_key_state", key_state, 0);
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_code", evt_code, 0);
      check("rst_overflow", overflow, 0);
      check("rst_evt_press", evt_press, RELEASE_EN ? 0 : 1);
      model_reset();
      pop_log.delete();
      valid_cycles = 0;
      rst      = 1'b0;
      model_on = 1'b1;
   endtask

   initial begin
      do_reset();
      check("row_cyc0", row_out, 4'b1111);
      step(1);  check("row_cyc1", row_out, 4'b1110);
      step(8);  check("row_cyc9", row_out, 4'b1101);
      step(8);  check("row_cyc17", row_out, 4'b1011);
      step(8);  check("row_cyc25", row_out, 4'b0111);
      step(8);  check("row_cyc33", row_out, 4'b1110);

      do_reset();
      evt_ready  = 1'b1;
      pressed[6] = 1'b1;
      step(128);
      check("press_key6_state", key_state[6], 1);
      check("press_evt_count", pop_log.size(), 1);
      check("press_evt", pop_log.size() > 0 ? pop_log[0] : 5'h1f, 5'b01101);
      check("press_valid_pulse", valid_cycles, 1);

      do_reset();
      evt_ready = 1'b1;
      pressed[6] = 1'b1; step(32);
      pressed[6] = 1'b0; step(32);
      pressed[6] = 1'b1; step(64);
      pressed[6] = 1'b0; step(64);
      check("bounce_key6_state", key_state[6], 0);
      check("bounce_evt_count", pop_log.size(), 0);
      pressed[6] = 1'b1; step(96);
      check("bounce3_key6_state", key_state[6], 1);
      check("bounce3_evt_count", pop_log.size(), 1);
      check("bounce3_evt", pop_log.size() > 0 ? pop_log[0] : 5'h1f, 5'b01101);

      pop_log.delete();
      pressed[6] = 1'b0;
      step(128);
      check("release_key6_state", key_state[6], 0);
`ifdef KEYPAD_RELEASE_EVT_EN
      check("release_evt_count", pop_log.size(), 1);
      check("release_evt", pop_log.size() > 0 ? pop_log[0] : 5'h1f, 5'b01100);
`else
      check("release_evt_count", pop_log.size(), 0);
`endif

      do_reset();
      evt_ready = 1'b0;
      pressed   = 16'h002F;
      step(128);
      check("ovf_valid", evt_valid, 1);
      check("ovf_head", evt_code, 0);
      check("ovf_flag", overflow, 1);
      evt_ready = 1'b1;
      step(8);
      check("ovf_pop_count", pop_log.size(), 4);
      for (int i = 0; i < 4; i++)
         check("ovf_pop_order", pop_log.size() > i ? pop_log[i] : 5'h1f, 5'(i * 2 + 1));
      check("ovf_sticky", overflow, 1);

      do_reset();
      evt_ready = 1'b0;
      pressed   = 16'h001F;
      step(80);
      check("coll_head0", evt_code, 0);
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      check("coll_head1", evt_code, 1);
      check("coll_no_ovf", overflow, 0);
      step(2);
      evt_ready = 1'b1;
      step(8);
      check("coll_pop_count", pop_log.size(), 5);
      for (int i = 0; i < 5; i++)
         check("coll_pop_order", pop_log.size() > i ? pop_log[i] : 5'h1f, 5'(i * 2 + 1));
      check("coll_ovf_final", overflow, 0);

      model_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      fails++;
      $display("FAIL watchdog: bench did not finish, time %0t", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
